mux_chan_reg: RTL and testbench

// - Parametrised, registered N-channel multiplexer with valid/ready handshake.
// - Successor to the fixed 4:1 x 2-bit combinational select tree.
// - Adds generic width and channel count, explicit-select and round-robin modes,
//   and a one-entry output register.
// - Sits between several producer lanes and one consumer in the datapath.

---
 rtl/mux_chan_reg.sv | 122 ++++++++++++
 tb/tb_mux_chan_reg.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_chan_reg.sv
// mux_chan_reg: registered N-channel multiplexer with valid/ready handshake.
//
// Selects one of NCH producer lanes, either by explicit index (mode=0, sel)
// or round-robin over the valid lanes (mode=1), and holds the chosen word
// in a one-entry output register towards a single consumer.
//
// Parameters:
//   WIDTH  data bits per channel
//   NCH    number of input channels (>=2)
//   SELW   select width, derived from NCH (do not override)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   mode       0 = explicit select via sel, 1 = round-robin
//   sel        channel index used when mode=0
//   in_data    channel i at bits [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, one-hot or zero
//   out_data   registered selected word
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer accepts out_data this cycle
//   out_ch     channel index of out_data (only with MUX_CH_TAG_EN)
//
// Build option: define MUX_CH_TAG_EN to add the out_ch tag output.
module mux_chan_reg #(
    parameter int WIDTH = 2,
    parameter int NCH   = 4,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef MUX_CH_TAG_EN
    ,
    output logic [SELW-1:0]      out_ch
`endif
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t            state, state_nxt;
    logic [SELW-1:0]   rr_ptr;
    logic [SELW-1:0]   gnt;
    logic [WIDTH-1:0]  gnt_data;
    logic              gnt_vld;
    logic              space;
    logic              load;

    // Grant selection. In round-robin mode the scan starts at rr_ptr and the
    // first valid lane found wins.
    always_comb begin
        int unsigned idx;
        gnt      = '0;
        gnt_data = '0;
        gnt_vld  = 1'b0;
        idx      = 0;
        if (!mode) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (sel == SELW'(i) && in_valid[i]) begin
                    gnt      = SELW'(i);
                    gnt_data = in_data[i*WIDTH +: WIDTH];
                    gnt_vld  = 1'b1;
                end
            end
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                idx = (32'(rr_ptr) + k) % NCH;
                if (!gnt_vld && in_valid[idx]) begin
                    gnt      = SELW'(idx);
                    gnt_data = in_data[idx*WIDTH +: WIDTH];
                    gnt_vld  = 1'b1;
                end
            end
        end
    end

    assign out_valid = (state == FULL);
    assign space     = !out_valid || out_ready;
    assign load      = gnt_vld && space && !rst;
    assign in_ready  = load ? (NCH'(1) << gnt) : '0;

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (load) state_nxt = FULL;
            FULL:  if (out_ready && !load) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            rr_ptr   <= '0;
        end else if (load) begin
            out_data <= gnt_data;
            if (mode)
                rr_ptr <= (gnt == SELW'(NCH - 1)) ? '0 : gnt + SELW'(1);
        end
    end

`ifdef MUX_CH_TAG_EN
    always_ff @(posedge clk) begin
        if (rst)       out_ch <= '0;
        else if (load) out_ch <= gnt;
    end
`endif

endmodule

// File: tb/tb_mux_chan_reg.sv
// tb_mux_chan_reg: scoreboard bench for mux_chan_reg.
//
// Stimulus pushes the expected {channel, data} of every word it expects to
// be delivered; a monitor pops and compares whenever the consumer drains a
// word. Direct checks cover reset, ready patterns, hold and no-grant cases.
// A second NCH=3 instance covers the out-of-range select.
module tb_mux_chan_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic [1:0] sel;
    logic [7:0] in_data;
    logic [3:0] in_valid;
    logic [3:0] in_ready;
    logic [1:0] out_data;
    logic       out_valid;
    logic       out_ready;
`ifdef MUX_CH_TAG_EN
    logic [1:0] out_ch;
`endif

    logic       mode3;
    logic [1:0] sel3;
    logic [5:0] data3;
    logic [2:0] valid3;
    logic [2:0] ready3;
    logic [1:0] od3;
    logic       ov3;
    logic       or3;
`ifdef MUX_CH_TAG_EN
    logic [1:0] ch3;
`endif

    int passed = 0;
    int total  = 0;
    logic [3:0] sbq[$];
    logic [3:0] e;

    always #5 clk = ~clk;

    mux_chan_reg #(.WIDTH(2), .NCH(4)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_CH_TAG_EN
        , .out_ch(out_ch)
`endif
    );

    mux_chan_reg #(.WIDTH(2), .NCH(3)) dut3 (
        .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
        .in_data(data3), .in_valid(valid3), .in_ready(ready3),
        .out_data(od3), .out_valid(ov3), .out_ready(or3)
`ifdef MUX_CH_TAG_EN
        , .out_ch(ch3)
`endif
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic expect_word(input logic [1:0] ch, input logic [1:0] d);
        sbq.push_back({ch, d});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic nedge;
        @(negedge clk);
    endtask

    // Monitor: a word is consumed at the next rising edge whenever
    // out_valid and out_ready are both high at the falling edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                total++;
                $display("FAIL unexpected_word: got %0h expected none", out_data);
            end else begin
                e = sbq.pop_front();
                chk("out_data", 32'(out_data), 32'(e[1:0]));
`ifdef MUX_CH_TAG_EN
                chk("out_ch", 32'(out_ch), 32'(e[3:2]));
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; mode = 1'b1; sel = 2'd0;
        in_data = 8'b10_01_11_10; in_valid = 4'b1111; out_ready = 1'b1;
        mode3 = 1'b0; sel3 = 2'd0; data3 = '0; valid3 = '0; or3 = 1'b1;

        // Reset held two clocks with active inputs
        tick;
        nedge;
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        tick;
        nedge;
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_valid2", 32'(out_valid), 32'h0);
`ifdef MUX_CH_TAG_EN
        chk("rst_out_ch", 32'(out_ch), 32'h0);
`endif
        tick;

        // Round-robin over all four lanes, wrap 3 -> 0
        rst = 1'b0;
        mode = 1'b1; in_data = 8'b11_10_01_00; in_valid = 4'b1111; out_ready = 1'b1;
        nedge; chk("rr_ready0", 32'(in_ready), 32'b0001); expect_word(2'd0, 2'b00); tick;
        nedge; chk("rr_ready1", 32'(in_ready), 32'b0010); expect_word(2'd1, 2'b01); tick;
        nedge; chk("rr_ready2", 32'(in_ready), 32'b0100); expect_word(2'd2, 2'b10); tick;
        nedge; chk("rr_ready3", 32'(in_ready), 32'b1000); expect_word(2'd3, 2'b11); tick;
        nedge; chk("rr_ready4", 32'(in_ready), 32'b0001); expect_word(2'd0, 2'b00); tick;
        in_valid = 4'b0000;
        nedge; tick;
        nedge; chk("rr_drained", 32'(out_valid), 32'h0);
        tick;

        // Explicit select of lane 2 (rr_ptr now 1, left unchanged)
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data = 8'b10_11_01_00;
        nedge; chk("sel2_ready", 32'(in_ready), 32'b0100); expect_word(2'd2, 2'b11); tick;
        in_valid = 4'b0000;
        nedge;
        chk("sel2_valid", 32'(out_valid), 32'h1);
        chk("sel2_data", 32'(out_data), 32'b11);
        tick;

        // Load, then hold three clocks with out_ready low
        mode = 1'b1; in_data = 8'b11_10_01_00; in_valid = 4'b1111; out_ready = 1'b0;
        nedge; chk("hold_load_ready", 32'(in_ready), 32'b0010); expect_word(2'd1, 2'b01); tick;
        for (int i = 0; i < 3; i++) begin
            nedge;
            chk("hold_ready", 32'(in_ready), 32'h0);
            chk("hold_data", 32'(out_data), 32'b01);
            chk("hold_valid", 32'(out_valid), 32'h1);
            tick;
        end
        out_ready = 1'b1;
        nedge; chk("drain_load_ready", 32'(in_ready), 32'b0100); expect_word(2'd2, 2'b10); tick;
        in_valid = 4'b0000;
        nedge; tick;

        // Round-robin skipping invalid lanes, starting from rr_ptr=3
        in_valid = 4'b0011;
        nedge; chk("skip_ready0", 32'(in_ready), 32'b0001); expect_word(2'd0, 2'b00); tick;
        nedge; chk("skip_ready1", 32'(in_ready), 32'b0010); expect_word(2'd1, 2'b01); tick;
        nedge; chk("skip_ready2", 32'(in_ready), 32'b0001); expect_word(2'd0, 2'b00); tick;
        in_valid = 4'b0000;
        nedge; tick;
        nedge; chk("skip_drained", 32'(out_valid), 32'h0);
        tick;

        // Explicit select of an invalid lane: no load, output drains
        mode = 1'b0; sel = 2'd0; in_valid = 4'b1101;
        nedge; chk("sel0_ready", 32'(in_ready), 32'b0001); expect_word(2'd0, 2'b00); tick;
        sel = 2'd1;
        mode3 = 1'b0; sel3 = 2'd3; data3 = 6'b10_01_11; valid3 = 3'b111; or3 = 1'b1;
        nedge;
        chk("sel1_ready", 32'(in_ready), 32'h0);
        chk("n3_sel3_ready", 32'(ready3), 32'h0);
        tick;
        nedge;
        chk("sel1_valid_fell", 32'(out_valid), 32'h0);
        chk("n3_sel3_valid", 32'(ov3), 32'h0);
        tick;
        sel3 = 2'd2;
        nedge; chk("n3_sel2_ready", 32'(ready3), 32'b100); tick;
        nedge;
        chk("n3_sel2_valid", 32'(ov3), 32'h1);
        chk("n3_sel2_data", 32'(od3), 32'b10);
`ifdef MUX_CH_TAG_EN
        chk("n3_sel2_ch", 32'(ch3), 32'h2);
`endif
        tick;
        valid3 = 3'b000;

        // Reset mid-stream discards the held word and rewinds rr_ptr
        sel = 2'd3; in_valid = 4'b1000; out_ready = 1'b0;
        nedge; chk("sel3_ready", 32'(in_ready), 32'b1000); tick;
        in_valid = 4'b0000;
        nedge;
        chk("pre_rst_valid", 32'(out_valid), 32'h1);
        chk("pre_rst_data", 32'(out_data), 32'b11);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0; mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        nedge;
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_data", 32'(out_data), 32'h0);
`ifdef MUX_CH_TAG_EN
        chk("mid_rst_ch", 32'(out_ch), 32'h0);
`endif
        chk("post_rst_ready", 32'(in_ready), 32'b0001);
        expect_word(2'd0, 2'b00);
        tick;
        in_valid = 4'b0000;
        nedge; tick;
        nedge;
        chk("scoreboard_empty", 32'(sbq.size()), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
